// File: rtl/pre_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pre_tx_arbiter
// Description : Multi-channel strobe-to-write front end for the TX FIFO.
//               Each channel shadows its payload while its strobe is low,
//               captures it on the strobe's rising edge, and a round-robin
//               arbiter issues one tagged FIFO write per Mclk falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module pre_tx_arbiter #(
   parameter int DATA_WIDTH  = 8,
   parameter int NUM_CH      = 4,
   parameter int CH_ID_WIDTH = 2
) (
   input  logic                              Mclk,
   input  logic                              Reset,
   input  logic [NUM_CH-1:0]                 Data_Available,
   input  logic [NUM_CH*DATA_WIDTH-1:0]      data_in,
   input  logic                              fifo_full,
   input  logic                              ovf_clr,
   output logic                              fifo_wrreq,
   output logic [CH_ID_WIDTH+DATA_WIDTH-1:0] fifo_data,
   output logic [NUM_CH-1:0]                 overflow
);

   // After reset the search starts just past the last channel, so channel 0
   // gets first priority.
   localparam logic [CH_ID_WIDTH-1:0] c_last_grant_rst = CH_ID_WIDTH'(NUM_CH - 1);

   logic [DATA_WIDTH-1:0]  r_shadow [NUM_CH];
   logic [DATA_WIDTH-1:0]  r_hold   [NUM_CH];
   logic [NUM_CH-1:0]      r_old;
   logic [NUM_CH-1:0]      r_pending;
   logic [CH_ID_WIDTH-1:0] r_last_grant;

   logic [NUM_CH-1:0]      w_rise;
   logic [NUM_CH-1:0]      w_ovf_set;
   logic [NUM_CH-1:0]      w_grant_oh;
   logic                   w_grant_vld;
   logic [CH_ID_WIDTH-1:0] w_grant_id;
   logic [DATA_WIDTH-1:0]  w_grant_data;
   int                     v_idx;

   // Rising-edge detect per channel; an overrun is a rise on a busy channel
   // that is not being drained in this same cycle.
   always_comb begin
      w_rise    = Data_Available & ~r_old;
      w_ovf_set = w_rise & r_pending & ~w_grant_oh;
   end

   // Round-robin search starting one past the last granted channel.
   always_comb begin
      w_grant_vld  = 1'b0;
      w_grant_id   = '0;
      w_grant_oh   = '0;
      w_grant_data = '0;
      v_idx        = 0;
      if (!fifo_full) begin
         for (int i = 1; i <= NUM_CH; i++) begin
            v_idx = int'(r_last_grant) + i;
            if (v_idx >= NUM_CH) begin
               v_idx = v_idx - NUM_CH;
            end
            if (!w_grant_vld && r_pending[v_idx]) begin
               w_grant_vld        = 1'b1;
               w_grant_id         = CH_ID_WIDTH'(v_idx);
               w_grant_oh[v_idx]  = 1'b1;
               w_grant_data       = r_hold[v_idx];
            end
         end
      end
   end

   // Per-channel shadow, capture and pending tracking.
   always_ff @(negedge Mclk or posedge Reset) begin
      if (Reset) begin
         for (int c = 0; c < NUM_CH; c++) begin
            r_shadow[c] <= '0;
            r_hold[c]   <= '0;
         end
         r_pending <= '0;
         // All ones: a strobe already high at release must be seen low first.
         r_old     <= '1;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (!Data_Available[c]) begin
               r_shadow[c] <= data_in[c*DATA_WIDTH +: DATA_WIDTH];
            end
            if (w_rise[c]) begin
               // A rise on a granted channel refills hold while the old
               // payload goes out, so the request stays pending.
               if (!r_pending[c] || w_grant_oh[c]) begin
                  r_hold[c]    <= r_shadow[c];
                  r_pending[c] <= 1'b1;
               end
            end else if (w_grant_oh[c]) begin
               r_pending[c] <= 1'b0;
            end
         end
         r_old <= Data_Available;
      end
   end

   // Registered FIFO write port and round-robin pointer.
   always_ff @(negedge Mclk or posedge Reset) begin
      if (Reset) begin
         fifo_wrreq   <= 1'b0;
         fifo_data    <= '0;
         r_last_grant <= c_last_grant_rst;
      end else if (w_grant_vld) begin
         fifo_wrreq   <= 1'b1;
         fifo_data    <= {w_grant_id, w_grant_data};
         r_last_grant <= w_grant_id;
      end else begin
         fifo_wrreq   <= 1'b0;
      end
   end

   // Sticky overrun flags; a new overrun wins over a simultaneous clear.
   always_ff @(negedge Mclk or posedge Reset) begin
      if (Reset) begin
         overflow <= '0;
      end else begin
         overflow <= (overflow & ~{NUM_CH{ovf_clr}}) | w_ovf_set;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pre_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pre_tx_arbiter
// Description : Scoreboard bench for pre_tx_arbiter (default parameters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pre_tx_arbiter;

   logic        Mclk;
   logic        Reset;
   logic [3:0]  Data_Available;
   logic [31:0] data_in;
   logic        fifo_full;
   logic        ovf_clr;
   logic        fifo_wrreq;
   logic [9:0]  fifo_data;
   logic [3:0]  overflow;

   logic [9:0]  exp_q [$];
   logic [9:0]  m_exp;
   int          total;
   int          bad;

   pre_tx_arbiter #(
      .DATA_WIDTH  (8),
      .NUM_CH      (4),
      .CH_ID_WIDTH (2)
   ) dut (
      .Mclk           (Mclk),
      .Reset          (Reset),
      .Data_Available (Data_Available),
      .data_in        (data_in),
      .fifo_full      (fifo_full),
      .ovf_clr        (ovf_clr),
      .fifo_wrreq     (fifo_wrreq),
      .fifo_data      (fifo_data),
      .overflow       (overflow)
   );

   initial Mclk = 1'b0;
   always #5 Mclk = ~Mclk;

   // Monitor: every write seen on the rising edge is matched in order.
   initial begin
      forever begin
         @(posedge Mclk);
         if (fifo_wrreq === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_write: got %h, required no write", fifo_data);
            end else begin
               m_exp = exp_q.pop_front();
               if (fifo_data !== m_exp) begin
                  bad++;
                  $display("FAIL write_data: got %h, required %h", fifo_data, m_exp);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge Mclk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // Present payloads with strobes low for one edge, then raise them together.
   task automatic strobe(input logic [3:0] mask, input logic [31:0] dat);
      logic [31:0] m;
      m = '0;
      for (int c = 0; c < 4; c++) begin
         if (mask[c]) m[c*8 +: 8] = 8'hFF;
      end
      data_in        = (data_in & ~m) | (dat & m);
      Data_Available = Data_Available & ~mask;
      tick();
      Data_Available = Data_Available | mask;
      tick();
   endtask

   task automatic pulse(input int ch, input logic [7:0] val);
      strobe(4'(1 << ch), 32'(val) << (8 * ch));
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
      repeat (3) tick();
      chk(name, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      total          = 0;
      bad            = 0;
      Reset          = 1'b1;
      Data_Available = 4'h0;
      data_in        = 32'h0;
      fifo_full      = 1'b0;
      ovf_clr        = 1'b0;
      repeat (3) tick();
      chk("rst_wrreq", 32'(fifo_wrreq), 32'd0);
      chk("rst_data", 32'(fifo_data), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      Reset = 1'b0;
      tick();

      // Simultaneous burst: channel 0 first after reset.
      exp_q.push_back(10'h010); exp_q.push_back(10'h111);
      exp_q.push_back(10'h212); exp_q.push_back(10'h313);
      strobe(4'hF, 32'h13121110);
      drain("burst1_drain");

      // Rotation: grant ch0 alone, then a full burst starts at ch1.
      exp_q.push_back(10'h020);
      pulse(0, 8'h20);
      drain("solo_drain");
      exp_q.push_back(10'h131); exp_q.push_back(10'h232);
      exp_q.push_back(10'h333); exp_q.push_back(10'h030);
      strobe(4'hF, 32'h33323130);
      drain("burst2_drain");

      // Single write; payload changes while the strobe is high are ignored.
      exp_q.push_back(10'h0A5);
      pulse(0, 8'hA5);
      data_in[7:0] = 8'hFF;
      drain("single_drain");

      // Backpressure holds the request without loss.
      fifo_full = 1'b1;
      pulse(2, 8'h5C);
      repeat (4) tick();
      exp_q.push_back(10'h25C);
      fifo_full = 1'b0;
      drain("bp_drain");
      chk("bp_ovf", 32'(overflow), 32'd0);

      // Overrun: second rise while pending is dropped and flagged.
      fifo_full = 1'b1;
      pulse(1, 8'h33);
      pulse(1, 8'h44);
      tick();
      chk("ovr_set", 32'(overflow), 32'h2);
      exp_q.push_back(10'h133);
      fifo_full = 1'b0;
      drain("ovr_drain");
      chk("ovr_sticky", 32'(overflow), 32'h2);
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0; tick();
      chk("ovr_clr", 32'(overflow), 32'h0);

      // Overrun coincident with clear: set wins.
      fifo_full = 1'b1;
      pulse(1, 8'h55);
      data_in[15:8] = 8'h66; Data_Available[1] = 1'b0; tick();
      Data_Available[1] = 1'b1; ovf_clr = 1'b1; tick();
      ovf_clr = 1'b0; tick();
      chk("ovr_setwins", 32'(overflow), 32'h2);
      exp_q.push_back(10'h155);
      fifo_full = 1'b0;
      drain("ovr2_drain");
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0; tick();
      chk("ovr_clr2", 32'(overflow), 32'h0);

      // Same-cycle rise and grant on ch3: both payloads go out in order.
      fifo_full = 1'b1;
      pulse(3, 8'h77);
      data_in[31:24] = 8'h88; Data_Available[3] = 1'b0; tick();
      exp_q.push_back(10'h377); exp_q.push_back(10'h388);
      Data_Available[3] = 1'b1; fifo_full = 1'b0; tick();
      drain("same_drain");
      chk("same_ovf", 32'(overflow), 32'h0);

      // Strobe held high across reset release writes nothing until re-raised.
      Data_Available = 4'h1; data_in[7:0] = 8'h99;
      Reset = 1'b1; tick(); Reset = 1'b0;
      repeat (5) tick();
      chk("rsthigh_quiet", 32'(exp_q.size()), 32'd0);
      exp_q.push_back(10'h099);
      Data_Available[0] = 1'b0; tick();
      Data_Available[0] = 1'b1; tick();
      drain("rsthigh_drain");

      // Mid-operation reset: clears outputs at once and drops pending work.
      fifo_full = 1'b1;
      strobe(4'hF, 32'h43424140);
      pulse(2, 8'hEE);
      tick();
      chk("mid_ovf", 32'(overflow), 32'h4);
      exp_q.push_back(10'h141);
      fifo_full = 1'b0;
      tick();
      Reset = 1'b1;
      #1;
      chk("mid_wrreq", 32'(fifo_wrreq), 32'd0);
      chk("mid_data", 32'(fifo_data), 32'd0);
      chk("mid_ovf0", 32'(overflow), 32'd0);
      Data_Available = 4'h0;
      repeat (2) tick();
      Reset = 1'b0;
      repeat (8) tick();
      chk("mid_queue", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, required finish");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/pre_tx_arbiter.md
# pre_tx_arbiter

Multi-channel front end for the TX FIFO. It generalises the single-channel pre-TX strobe-to-write converter to NUM_CH independent byte sources of parametrised width. Each channel shadows its data while its Data_Available strobe is low and latches it on the strobe's rising edge. A round-robin arbiter then issues one tagged FIFO write per cycle, honouring FIFO-full backpressure and flagging per-channel overruns. It sits between the source channels and the single write port of the TX FIFO.

## Interface
Parameters:
- DATA_WIDTH, 8: payload bits per channel.
- NUM_CH, 4: number of source channels (2..16).
- CH_ID_WIDTH, 2: channel tag width; must satisfy 2^CH_ID_WIDTH >= NUM_CH.

Ports:
- Mclk  in  1  clock; all state updates on the falling edge of Mclk.
- Reset  in  1  asynchronous, active-high reset.
- Data_Available  in  NUM_CH  per-channel strobe; its rising edge requests a write. Synchronous to Mclk.
- data_in  in  NUM_CH*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- fifo_full  in  1  TX FIFO full; no write is issued while it is high.
- ovf_clr  in  1  clears all overflow flags.
- fifo_wrreq  out  1  one-cycle write strobe to the TX FIFO.
- fifo_data  out  CH_ID_WIDTH+DATA_WIDTH  {channel id, payload}, valid while fifo_wrreq is high.
- overflow  out  NUM_CH  sticky per-channel overrun flags.

## Operation
Per channel c, all updates at each falling edge of Mclk:
- Shadow register: while Data_Available[c]=0, shadow[c] <= data_in slice. While the strobe is high, shadow[c] holds its value.
- Edge detect: rise[c] = Data_Available[c] & ~old[c]; then old[c] <= Data_Available[c].
- On rise[c] with pending[c]=0: hold[c] <= shadow[c] and pending[c] <= 1. The latched payload is the last value sampled while the strobe was low.
- On rise[c] with pending[c]=1 and channel c not granted this cycle: overflow[c] <= 1. The new payload is dropped and hold[c] is unchanged.
- On rise[c] in the same cycle that channel c is granted: the old hold[c] is written out, hold[c] <= new shadow, and pending[c] stays 1. No overflow is flagged.

Arbiter:
- When fifo_full=0 and any pending bit is set, grant the first pending channel searching from last_grant+1 upward, with modular wrap at NUM_CH.
- On a grant: fifo_wrreq <= 1, fifo_data <= {grant id, hold[grant]}, pending[grant] cleared (except for the same-cycle rise case above), last_grant <= grant.
- Otherwise fifo_wrreq <= 0 and fifo_data holds its last value.
- At most one write per cycle. fifo_wrreq never stays high two consecutive cycles for the same request.
- The channel id is zero-extended to CH_ID_WIDTH.

Overflow flags:
- ovf_clr=1 clears all overflow bits.
- A new overrun in the same cycle as ovf_clr sets its bit; set wins over clear.

Reset (asynchronous, takes effect immediately on Reset=1):
- fifo_wrreq=0, fifo_data=0, overflow=0.
- pending=0, hold=0, shadow=0.
- old = all ones, so a strobe already high at reset release produces no write until it has been seen low.
- last_grant = NUM_CH-1, so channel 0 has first priority.
- Reset asserted mid-operation discards every pending request and any write in flight.

## Timing
- Rise sampled at falling edge n: pending is set at edge n. The grant is evaluated at edge n+1, so fifo_wrreq is high from edge n+1 to edge n+2 when fifo_full=0. Latency is one cycle.
- fifo_full is sampled at the same edge that would assert fifo_wrreq. When it is high, that edge produces no write and requests stay pending indefinitely without loss until an overrun occurs.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Sustained throughput is one write per cycle across channels. Each channel accepts at most one outstanding request.

## Test plan
- Single channel, defaults: data_in ch0=0xA5 while low, raise Data_Available[0] at edge 0 → fifo_wrreq high for exactly one cycle after edge 1, fifo_data=0x0A5 ({2'd0,8'hA5}). Payload changes while the strobe is high are ignored.
- Simultaneous rises on ch0..ch3 with payloads 0x10/0x11/0x12/0x13 → four back-to-back writes with fifo_data 0x010, 0x111, 0x212, 0x313. A second burst is then granted in rotation starting after the last grant.
- Backpressure: fifo_full=1 while ch2 rises with 0x5C → no write. Drop fifo_full → a single write of 0x25C on the next edge, and overflow stays 0.
- Overrun: with fifo_full=1, pulse ch1 with 0x33 then 0x44 → overflow[1]=1 and only 0x133 is written after release. ovf_clr then clears the flag; ovf_clr coincident with a new overrun leaves the flag at 1.
- Reset behaviour: hold Data_Available[0]=1 across Reset release → no write until the strobe goes low and then rises again. Assert Reset with ch0..ch3 pending → all outputs go to 0 immediately and no writes occur afterwards.
- Same-cycle rise and grant on ch3 (0x77 granted, new 0x88 arriving) → both 0x377 and 0x388 are written in order, with overflow[3]=0.
